// File: rtl/stage_e_exec_if.sv
// Execute-stage bundle: E-stage operands and controls in, E/M register contents and
// md_busy out. The master side drives the E-stage fields, the slave side is the stage itself.
interface stage_e_exec_if;
  logic [31:0] PC_E;
  logic [31:0] instr_E;
  logic [31:0] v_rs_E;
  logic [31:0] v_rt_E;
  logic [31:0] imm32_E;
  logic        alu_bsel_E;
  logic [3:0]  alu_op_E;
  logic [2:0]  md_op_E;
  logic [4:0]  a_R3_E;
  logic [31:0] v_R3_E;
  logic [1:0]  R3_sel_E;

  logic        md_busy;
  logic [31:0] PC_M;
  logic [31:0] instrM;
  logic [31:0] ALUout_M;
  logic [31:0] fwdM2;
  logic [4:0]  a_R3_M;
  logic [31:0] v_R3_M;

  modport master (
    output PC_E, instr_E, v_rs_E, v_rt_E, imm32_E, alu_bsel_E, alu_op_E, md_op_E,
           a_R3_E, v_R3_E, R3_sel_E,
    input  md_busy, PC_M, instrM, ALUout_M, fwdM2, a_R3_M, v_R3_M
  );

  modport slave (
    input  PC_E, instr_E, v_rs_E, v_rt_E, imm32_E, alu_bsel_E, alu_op_E, md_op_E,
           a_R3_E, v_R3_E, R3_sel_E,
    output md_busy, PC_M, instrM, ALUout_M, fwdM2, a_R3_M, v_R3_M
  );
endinterface

// File: rtl/stage_e_exec.sv
// Execute stage: ALU, iterative multiply/divide unit with HI/LO, and the E/M pipeline register.
// The MD result is computed at start and held in shadow registers until the countdown ends.
module stage_e_exec #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  stage_e_exec_if.slave e
);
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluOr   = 4'd2;
  localparam logic [3:0] AluAnd  = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluNor  = 4'd5;
  localparam logic [3:0] AluSlt  = 4'd6;
  localparam logic [3:0] AluSltu = 4'd7;
  localparam logic [3:0] AluLui  = 4'd8;
  localparam logic [3:0] AluSll  = 4'd9;
  localparam logic [3:0] AluSrl  = 4'd10;
  localparam logic [3:0] AluSra  = 4'd11;

  localparam logic [2:0] MdMult  = 3'd1;
  localparam logic [2:0] MdMultu = 3'd2;
  localparam logic [2:0] MdDiv   = 3'd3;
  localparam logic [2:0] MdDivu  = 3'd4;
  localparam logic [2:0] MdMthi  = 3'd5;
  localparam logic [2:0] MdMtlo  = 3'd6;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        shadow_hi_q, shadow_hi_d, shadow_lo_q, shadow_lo_d;
  logic               start;
  logic [31:0]        alu_b, alu_res;
  logic [4:0]         shamt;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic [31:0]        divisor;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic [31:0]        v_r3_sel;

  assign start     = (e.md_op_E >= MdMult) && (e.md_op_E <= MdDivu) && (cnt_q == '0);
  assign e.md_busy = start | (cnt_q != '0);

  always_comb begin
    alu_b = e.alu_bsel_E ? e.imm32_E : e.v_rt_E;
    shamt = e.instr_E[10:6];
    case (e.alu_op_E)
      AluAdd:  alu_res = e.v_rs_E + alu_b;
      AluSub:  alu_res = e.v_rs_E - alu_b;
      AluOr:   alu_res = e.v_rs_E | alu_b;
      AluAnd:  alu_res = e.v_rs_E & alu_b;
      AluXor:  alu_res = e.v_rs_E ^ alu_b;
      AluNor:  alu_res = ~(e.v_rs_E | alu_b);
      AluSlt:  alu_res = {31'd0, $signed(e.v_rs_E) < $signed(alu_b)};
      AluSltu: alu_res = {31'd0, e.v_rs_E < alu_b};
      AluLui:  alu_res = {alu_b[15:0], 16'd0};
      AluSll:  alu_res = e.v_rt_E << shamt;
      AluSrl:  alu_res = e.v_rt_E >> shamt;
      AluSra:  alu_res = $unsigned($signed(e.v_rt_E) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Divisor is forced to 1 on divide-by-zero so the dividers never see zero.
  always_comb begin
    div_zero = (e.v_rt_E == '0);
    divisor  = div_zero ? 32'd1 : e.v_rt_E;
    prod_s   = $signed({{32{e.v_rs_E[31]}}, e.v_rs_E}) * $signed({{32{e.v_rt_E[31]}}, e.v_rt_E});
    prod_u   = {32'd0, e.v_rs_E} * {32'd0, e.v_rt_E};
    quot_s   = $signed(e.v_rs_E) / $signed(divisor);
    rem_s    = $signed(e.v_rs_E) % $signed(divisor);
    quot_u   = e.v_rs_E / divisor;
    rem_u    = e.v_rs_E % divisor;
  end

  always_comb begin
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    if (cnt_q != '0) begin
      // Any MD op arriving mid-sequence is ignored.
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        hi_d = shadow_hi_q;
        lo_d = shadow_lo_q;
      end
    end else begin
      case (e.md_op_E)
        MdMult: begin
          {shadow_hi_d, shadow_lo_d} = prod_s;
          cnt_d = CntW'(MULT_CYCLES);
        end
        MdMultu: begin
          {shadow_hi_d, shadow_lo_d} = prod_u;
          cnt_d = CntW'(MULT_CYCLES);
        end
        MdDiv: begin
          shadow_hi_d = div_zero ? hi_q : rem_s;
          shadow_lo_d = div_zero ? lo_q : quot_s;
          cnt_d = CntW'(DIV_CYCLES);
        end
        MdDivu: begin
          shadow_hi_d = div_zero ? hi_q : rem_u;
          shadow_lo_d = div_zero ? lo_q : quot_u;
          cnt_d = CntW'(DIV_CYCLES);
        end
        MdMthi:  hi_d = e.v_rs_E;
        MdMtlo:  lo_d = e.v_rs_E;
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (e.R3_sel_E)
      2'd0: v_r3_sel = e.v_R3_E;
      2'd1: v_r3_sel = alu_res;
      2'd2: v_r3_sel = hi_q;
      2'd3: v_r3_sel = lo_q;
      default: v_r3_sel = e.v_R3_E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
      e.PC_M      <= '0;
      e.instrM    <= '0;
      e.ALUout_M  <= '0;
      e.fwdM2     <= '0;
      e.a_R3_M    <= '0;
      e.v_R3_M    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      e.PC_M      <= e.PC_E;
      e.instrM    <= e.instr_E;
      e.ALUout_M  <= alu_res;
      e.fwdM2     <= e.v_rt_E;
      e.a_R3_M    <= e.a_R3_E;
      e.v_R3_M    <= v_r3_sel;
    end
  end
endmodule

// File: tb/tb_stage_e_exec.sv
// Self-checking bench for stage_e_exec: randomized ALU and MD operations against an
// arithmetic reference model, plus directed reset, latency, abort and injection scenarios.
module tb_stage_e_exec;
  localparam int unsigned MultCycles = 5;
  localparam int unsigned DivCycles  = 10;

  logic clk;
  logic reset;
  stage_e_exec_if bus ();

  stage_e_exec #(
    .MULT_CYCLES(MultCycles),
    .DIV_CYCLES (DivCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .e    (bus)
  );

  int          passed     = 0;
  int          total      = 0;
  logic [31:0] hi_m       = '0;
  logic [31:0] lo_m       = '0;
  logic        inject_ok  = 1'b0;
  int          mon_cnt    = 0;
  int          proto_viol = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (passed=%0d total=%0d)", passed, total);
    $fatal(1);
  end

  // Tracks when the MD unit is mid-sequence so stray MD ops can be flagged.
  always @(posedge clk) begin
    if (!reset && mon_cnt != 0 && bus.md_op_E != 3'd0 && !inject_ok)
      proto_viol <= proto_viol + 1;
    if (reset) mon_cnt <= 0;
    else if (mon_cnt != 0) mon_cnt <= mon_cnt - 1;
    else if (bus.md_op_E == 3'd1 || bus.md_op_E == 3'd2) mon_cnt <= int'(MultCycles);
    else if (bus.md_op_E == 3'd3 || bus.md_op_E == 3'd4) mon_cnt <= int'(DivCycles);
  end

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] rt, input logic [31:0] imm,
                                            input logic bsel, input logic [4:0] sh);
    logic [31:0] b, p2;
    b  = bsel ? imm : rt;
    p2 = 32'd1 << sh;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a | b;
      4'd3:  return a & b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b * 32'd65536;
      4'd9:  return rt * p2;
      4'd10: return rt / p2;
      4'd11: return rt[31] ? ~((~rt) / p2) : rt / p2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void md_model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] hi_in,
                                   input logic [31:0] lo_in, output logic [31:0] hi_o,
                                   output logic [31:0] lo_o);
    longint      p;
    logic [31:0] ma, mb, q, r;
    hi_o = hi_in;
    lo_o = lo_in;
    case (op)
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {hi_o, lo_o} = p; end
      3'd2: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); {hi_o, lo_o} = p; end
      3'd3: if (b != 32'd0) begin
        ma = a[31] ? 32'd0 - a : a;
        mb = b[31] ? 32'd0 - b : b;
        q  = ma / mb;
        r  = ma % mb;
        lo_o = (a[31] ^ b[31]) ? 32'd0 - q : q;
        hi_o = a[31] ? 32'd0 - r : r;
      end
      3'd4: if (b != 32'd0) begin lo_o = a / b; hi_o = a % b; end
      default: ;
    endcase
  endfunction

  task automatic idle();
    bus.PC_E = '0; bus.instr_E = '0; bus.v_rs_E = '0; bus.v_rt_E = '0; bus.imm32_E = '0;
    bus.alu_bsel_E = 1'b0; bus.alu_op_E = '0; bus.md_op_E = '0; bus.a_R3_E = '0;
    bus.v_R3_E = '0; bus.R3_sel_E = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({bus.PC_M, bus.instrM, bus.ALUout_M, bus.fwdM2, bus.a_R3_M, bus.v_R3_M} !== '0)
      $display("FAIL reset_m_outputs got=%h/%h/%h/%h/%h/%h exp=all zero", bus.PC_M,
               bus.instrM, bus.ALUout_M, bus.fwdM2, bus.a_R3_M, bus.v_R3_M);
    else passed++;
    total++;
    if (bus.md_busy !== 1'b0) $display("FAIL reset_md_busy got=%b exp=0", bus.md_busy);
    else passed++;
    bus.R3_sel_E = 2'd2; bus.a_R3_E = 5'd3; bus.v_R3_E = 32'hFFFF_FFFF;
    tick();
    total++;
    if ({bus.a_R3_M, bus.v_R3_M} !== {5'd3, 32'd0})
      $display("FAIL reset_mfhi got a=%0d v=%h exp a=3 v=0", bus.a_R3_M, bus.v_R3_M);
    else passed++;
  endtask

  task automatic test_alu();
    logic [3:0]  op;
    logic [31:0] a, rt, imm, pc, ins, vr3, exp_alu;
    logic [4:0]  sh, ar3;
    logic        bsel, sel;
    for (int k = 0; k < 160; k++) begin
      op = 4'($urandom_range(0, 11)); a = $urandom; rt = $urandom; imm = $urandom;
      bsel = 1'($urandom_range(0, 1)); sh = 5'($urandom_range(0, 31));
      case (k)
        0: begin op = 4'd0; a = 32'h7FFF_FFFF; rt = 32'd1; bsel = 1'b0; end
        1: begin op = 4'd6; a = 32'hFFFF_FFFF; rt = 32'd1; bsel = 1'b0; end
        2: begin op = 4'd7; a = 32'hFFFF_FFFF; rt = 32'd1; bsel = 1'b0; end
        3: begin op = 4'd11; rt = 32'h8000_0000; sh = 5'd4; end
        4: begin op = 4'd8; imm = 32'h0000_1234; bsel = 1'b1; end
        default: ;
      endcase
      exp_alu = alu_model(op, a, rt, imm, bsel, sh);
      case (k)
        0: exp_alu = 32'h8000_0000;
        1: exp_alu = 32'd1;
        2: exp_alu = 32'd0;
        3: exp_alu = 32'hF800_0000;
        4: exp_alu = 32'h1234_0000;
        default: ;
      endcase
      pc = $urandom; ins = $urandom; ins[10:6] = sh; vr3 = $urandom;
      ar3 = 5'($urandom_range(0, 31)); sel = 1'($urandom_range(0, 1));
      idle();
      bus.PC_E = pc; bus.instr_E = ins; bus.v_rs_E = a; bus.v_rt_E = rt; bus.imm32_E = imm;
      bus.alu_bsel_E = bsel; bus.alu_op_E = op; bus.a_R3_E = ar3; bus.v_R3_E = vr3;
      bus.R3_sel_E = {1'b0, sel};
      tick();
      total++;
      if (bus.ALUout_M !== exp_alu)
        $display("FAIL alu_out k=%0d op=%0d got=%h exp=%h", k, op, bus.ALUout_M, exp_alu);
      else passed++;
      total++;
      if (bus.v_R3_M !== (sel ? exp_alu : vr3))
        $display("FAIL alu_v_r3 k=%0d sel=%0d got=%h exp=%h", k, sel, bus.v_R3_M,
                 sel ? exp_alu : vr3);
      else passed++;
      total++;
      if ({bus.PC_M, bus.instrM, bus.fwdM2, bus.a_R3_M} !== {pc, ins, rt, ar3})
        $display("FAIL alu_passthru k=%0d got=%h/%h/%h/%0d exp=%h/%h/%h/%0d", k, bus.PC_M,
                 bus.instrM, bus.fwdM2, bus.a_R3_M, pc, ins, rt, ar3);
      else passed++;
    end
  endtask

  task automatic test_md();
    logic [2:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo, old_lo;
    int          n;
    for (int k = 0; k < 24; k++) begin
      op = 3'(1 + $urandom_range(0, 3)); a = $urandom; b = $urandom;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) b = 32'd0 - b;
      if (op >= 3'd3 && $urandom_range(0, 5) == 0) b = 32'd0;
      if (op == 3'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      case (k)
        0: begin op = 3'd1; a = 32'hFFFF_FFFF; b = 32'd2; end
        1: begin op = 3'd2; a = 32'hFFFF_FFFF; b = 32'd2; end
        2: begin op = 3'd3; a = 32'hFFFF_FFF9; b = 32'd2; end
        3: begin op = 3'd3; a = $urandom; b = 32'd0; end
        default: ;
      endcase
      md_model(op, a, b, hi_m, lo_m, exp_hi, exp_lo);
      case (k)
        0: {exp_hi, exp_lo} = {32'hFFFF_FFFF, 32'hFFFF_FFFE};
        1: {exp_hi, exp_lo} = {32'h0000_0001, 32'hFFFF_FFFE};
        2: {exp_hi, exp_lo} = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        3: {exp_hi, exp_lo} = {hi_m, lo_m};
        default: ;
      endcase
      n = (op <= 3'd2) ? int'(MultCycles) : int'(DivCycles);
      old_lo = lo_m;
      idle();
      bus.md_op_E = op; bus.v_rs_E = a; bus.v_rt_E = b;
      #1;
      total++;
      if (bus.md_busy !== 1'b1) $display("FAIL md_busy_start k=%0d got=%b exp=1", k, bus.md_busy);
      else passed++;
      for (int c = 1; c <= n; c++) begin
        tick();
        idle();
        if (c == n) bus.R3_sel_E = 2'd3;
        #1;
        total++;
        if (bus.md_busy !== 1'b1)
          $display("FAIL md_busy_hold k=%0d cycle=t+%0d got=%b exp=1", k, c, bus.md_busy);
        else passed++;
      end
      tick();
      idle();
      bus.R3_sel_E = 2'd2;
      #1;
      total++;
      if (bus.v_R3_M !== old_lo)
        $display("FAIL md_lo_before_commit k=%0d got=%h exp=%h", k, bus.v_R3_M, old_lo);
      else passed++;
      total++;
      if (bus.md_busy !== 1'b0) $display("FAIL md_busy_done k=%0d got=%b exp=0", k, bus.md_busy);
      else passed++;
      tick();
      idle();
      bus.R3_sel_E = 2'd3;
      total++;
      if (bus.v_R3_M !== exp_hi)
        $display("FAIL md_hi k=%0d op=%0d a=%h b=%h got=%h exp=%h", k, op, a, b, bus.v_R3_M,
                 exp_hi);
      else passed++;
      tick();
      idle();
      total++;
      if (bus.v_R3_M !== exp_lo)
        $display("FAIL md_lo k=%0d op=%0d a=%h b=%h got=%h exp=%h", k, op, a, b, bus.v_R3_M,
                 exp_lo);
      else passed++;
      hi_m = exp_hi;
      lo_m = exp_lo;
    end
  endtask

  task automatic test_mtlo();
    logic [31:0] v;
    idle();
    bus.md_op_E = 3'd6; bus.v_rs_E = 32'h0000_1234;
    #1;
    total++;
    if (bus.md_busy !== 1'b0) $display("FAIL mtlo_busy got=%b exp=0", bus.md_busy);
    else passed++;
    tick();
    idle();
    bus.R3_sel_E = 2'd3;
    tick();
    total++;
    if (bus.v_R3_M !== 32'h0000_1234) $display("FAIL mflo got=%h exp=00001234", bus.v_R3_M);
    else passed++;
    v = $urandom;
    idle();
    bus.md_op_E = 3'd5; bus.v_rs_E = v;
    tick();
    idle();
    bus.R3_sel_E = 2'd2;
    tick();
    total++;
    if (bus.v_R3_M !== v) $display("FAIL mfhi got=%h exp=%h", bus.v_R3_M, v);
    else passed++;
    idle();
    bus.R3_sel_E = 2'd3;
    tick();
    total++;
    if (bus.v_R3_M !== 32'h0000_1234) $display("FAIL lo_kept got=%h exp=00001234", bus.v_R3_M);
    else passed++;
    hi_m = v;
    lo_m = 32'h0000_1234;
  endtask

  task automatic test_inject();
    logic [31:0] a, b, exp_hi, exp_lo;
    a = $urandom; b = $urandom;
    md_model(3'd1, a, b, hi_m, lo_m, exp_hi, exp_lo);
    inject_ok = 1'b1;
    idle();
    bus.md_op_E = 3'd1; bus.v_rs_E = a; bus.v_rt_E = b;
    tick();
    idle();
    bus.md_op_E = 3'd1; bus.v_rs_E = $urandom; bus.v_rt_E = $urandom;
    tick();
    idle();
    bus.md_op_E = 3'd6; bus.v_rs_E = 32'h0000_DEAD;
    tick();
    idle();
    bus.md_op_E = 3'd3; bus.v_rs_E = $urandom; bus.v_rt_E = 32'd5;
    tick();
    idle();
    tick();
    total++;
    if (bus.md_busy !== 1'b1) $display("FAIL inject_busy_last got=%b exp=1", bus.md_busy);
    else passed++;
    tick();
    inject_ok = 1'b0;
    total++;
    if (bus.md_busy !== 1'b0) $display("FAIL inject_busy_done got=%b exp=0", bus.md_busy);
    else passed++;
    bus.R3_sel_E = 2'd2;
    tick();
    bus.R3_sel_E = 2'd3;
    total++;
    if (bus.v_R3_M !== exp_hi) $display("FAIL inject_hi got=%h exp=%h", bus.v_R3_M, exp_hi);
    else passed++;
    tick();
    idle();
    total++;
    if (bus.v_R3_M !== exp_lo) $display("FAIL inject_lo got=%h exp=%h", bus.v_R3_M, exp_lo);
    else passed++;
    hi_m = exp_hi;
    lo_m = exp_lo;
  endtask

  task automatic test_reset_abort();
    int bad;
    idle();
    bus.md_op_E = 3'd5; bus.v_rs_E = 32'h0000_AAAA;
    tick();
    idle();
    bus.md_op_E = 3'd6; bus.v_rs_E = 32'h0000_5555;
    tick();
    idle();
    bus.md_op_E = 3'd3; bus.v_rs_E = $urandom | 32'd1; bus.v_rt_E = 32'd7;
    bus.PC_E = 32'h0000_0400;
    tick();
    idle();
    bus.PC_E = 32'h0000_0404;
    tick();
    idle();
    bus.PC_E = 32'h0000_0408;
    tick();
    idle();
    bus.PC_E = 32'h0000_040C; bus.v_R3_E = 32'h0000_0077; bus.a_R3_E = 5'd9;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1;
    total++;
    if (bus.md_busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus.md_busy);
    else passed++;
    total++;
    if ({bus.PC_M, bus.a_R3_M, bus.v_R3_M} !== '0)
      $display("FAIL abort_m_outputs got=%h/%0d/%h exp=0/0/0", bus.PC_M, bus.a_R3_M, bus.v_R3_M);
    else passed++;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.md_busy !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL abort_stays_idle got=%0d busy cycles exp=0", bad);
    else passed++;
    bus.R3_sel_E = 2'd2;
    tick();
    bus.R3_sel_E = 2'd3;
    total++;
    if (bus.v_R3_M !== 32'd0) $display("FAIL abort_hi got=%h exp=0", bus.v_R3_M);
    else passed++;
    tick();
    idle();
    total++;
    if (bus.v_R3_M !== 32'd0) $display("FAIL abort_lo got=%h exp=0", bus.v_R3_M);
    else passed++;
    hi_m = '0;
    lo_m = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_alu();
    test_md();
    test_mtlo();
    test_inject();
    test_reset_abort();
    total++;
    if (proto_viol != 0) $display("FAIL md_protocol got=%0d stray ops exp=0", proto_viol);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
